// File: rtl/fpu_cpx_obuf.sv
// obuf_fifo: generic single-clock FIFO with first-word-fall-through head.
// Latency: a push is visible on head_dat/cnt the cycle after push_vld.
// Backpressure: none inside; caller never pushes when full unless also popping, never pops when empty.
module obuf_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_vld,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop_vld,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_vld, pop_vld})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed while cnt is non-zero.
    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

// fpu_cpx_obuf: FPU-to-CPX output buffer, one REQ/WAIT handshake per packet.
// Latency: request in N, FIFO write end of N+1, CPX request earliest N+3, data from N+4.
// Backpressure: obuf_stall tells upstream to hold requests; a write into a full FIFO is dropped (ovfl_err).
// Ports: rclk/grst clock and sync reset; fp_cpx_req_cq/fp_cpx_data_ca upstream packet (data one cycle
//        after request); cpx_fp_grant_cx one-hot grant; fpu_cpx_req_cq/fpu_cpx_data_ca to CPX;
//        obuf_stall, obuf_cnt occupancy, sticky ovfl_err and tmo_err.
// DEPTH must be a power of two and at least 4.
module fpu_cpx_obuf #(
    parameter int DEPTH   = 4,
    parameter int TMO_CYC = 255
) (
    input  logic                   rclk,
    input  logic                   grst,
    input  logic [7:0]             fp_cpx_req_cq,
    input  logic [144:0]           fp_cpx_data_ca,
    input  logic [7:0]             cpx_fp_grant_cx,
    output logic [7:0]             fpu_cpx_req_cq,
    output logic [144:0]           fpu_cpx_data_ca,
    output logic                   obuf_stall,
    output logic [$clog2(DEPTH):0] obuf_cnt,
    output logic                   ovfl_err,
    output logic                   tmo_err
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TMO_CYC + 1);

    typedef struct packed {
        logic [7:0]   dest;
        logic [144:0] dat;
    } pkt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    req_ca;
    logic          req_ca_vld;
    pkt_t          wr_pkt;
    pkt_t          head;
    logic          full;
    logic          hit;
    logic          pop_vld;
    logic          push_vld;
    logic          ovfl_set;
    logic [CW:0]   occ;
    logic [TW-1:0] wait_cnt;

    // Request stage: data for a request arrives one cycle later, so the
    // destination is held here and merged with the data at write time.
    always_ff @(posedge rclk) begin
        if (grst) req_ca <= '0;
        else      req_ca <= fp_cpx_req_cq;
    end

    assign req_ca_vld = |req_ca;
    assign wr_pkt     = '{dest: req_ca, dat: fp_cpx_data_ca};

    assign full     = (obuf_cnt == CW'(DEPTH));
    assign hit      = (state == WAIT) && |(cpx_fp_grant_cx & head.dest);
    assign pop_vld  = hit;
    // A pop in the same cycle frees the slot, so push-while-full is legal then.
    assign push_vld = req_ca_vld && (!full || pop_vld);
    assign ovfl_set = req_ca_vld && full && !pop_vld;

    obuf_fifo #(
        .W     ($bits(pkt_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (rclk),
        .rst      (grst),
        .push_vld (push_vld),
        .push_dat (wr_pkt),
        .pop_vld  (pop_vld),
        .head_dat (head),
        .cnt      (obuf_cnt)
    );

    // Counting the packet still in the request stage keeps one slot of slack
    // for a request already launched in the cycle the stall rises.
    assign occ        = {1'b0, obuf_cnt} + {{CW{1'b0}}, req_ca_vld};
    assign obuf_stall = (occ >= (CW + 1)'(DEPTH - 1));

    always_ff @(posedge rclk) begin
        if (grst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        fpu_cpx_req_cq  = '0;
        fpu_cpx_data_ca = '0;
        case (state)
            IDLE: begin
                if (obuf_cnt != '0) state_nxt = REQ;
            end
            REQ: begin
                fpu_cpx_req_cq = head.dest;
                state_nxt      = WAIT;
            end
            WAIT: begin
                fpu_cpx_data_ca = head.dat;
                // Entries remaining after the pop include a same-cycle push.
                if (hit) state_nxt = ((obuf_cnt > CW'(1)) || push_vld) ? REQ : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Wait counter holds the number of grant-less WAIT cycles so far; the
    // flag rises in the same edge the counter reaches TMO_CYC.
    always_ff @(posedge rclk) begin
        if (grst) begin
            wait_cnt <= '0;
            tmo_err  <= 1'b0;
            ovfl_err <= 1'b0;
        end else begin
            if (state == REQ) begin
                wait_cnt <= '0;
            end else if ((state == WAIT) && !hit && (wait_cnt != TW'(TMO_CYC))) begin
                wait_cnt <= wait_cnt + 1'b1;
                if (wait_cnt == TW'(TMO_CYC - 1)) tmo_err <= 1'b1;
            end
            if (ovfl_set) ovfl_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fpu_cpx_obuf.sv
module tb_fpu_cpx_obuf;
    logic         rclk = 1'b0;
    logic         grst;
    logic [7:0]   fp_cpx_req_cq;
    logic [144:0] fp_cpx_data_ca;
    logic [7:0]   cpx_fp_grant_cx;
    logic [7:0]   fpu_cpx_req_cq;
    logic [144:0] fpu_cpx_data_ca;
    logic         obuf_stall;
    logic [2:0]   obuf_cnt;
    logic         ovfl_err;
    logic         tmo_err;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [144:0] D_ABCD = 145'h1_ABCD;
    localparam logic [144:0] D1 = {1'b1, 144'hCAFE_0000_0000_0000_0000_0000_0000_0000_0001};
    localparam logic [144:0] D2 = {1'b0, 144'h0000_1111_2222_3333_4444_5555_6666_7777_0002};
    localparam logic [144:0] D3 = {1'b1, 144'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000_0003};
    localparam logic [144:0] D4 = {1'b0, 144'h8000_0000_0000_0000_0000_0000_0000_0000_0004};
    localparam logic [144:0] D5 = {1'b1, 144'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_0005};
    localparam logic [144:0] D6 = {1'b0, 144'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0_0006};

    fpu_cpx_obuf #(.DEPTH(4), .TMO_CYC(255)) dut (
        .rclk            (rclk),
        .grst            (grst),
        .fp_cpx_req_cq   (fp_cpx_req_cq),
        .fp_cpx_data_ca  (fp_cpx_data_ca),
        .cpx_fp_grant_cx (cpx_fp_grant_cx),
        .fpu_cpx_req_cq  (fpu_cpx_req_cq),
        .fpu_cpx_data_ca (fpu_cpx_data_ca),
        .obuf_stall      (obuf_stall),
        .obuf_cnt        (obuf_cnt),
        .ovfl_err        (ovfl_err),
        .tmo_err         (tmo_err)
    );

    always #5 rclk = ~rclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Each cycle starts 1 time unit after a rising edge.
    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        grst = 1'b1;
        fp_cpx_req_cq = '0;
        fp_cpx_data_ca = '0;
        cpx_fp_grant_cx = '0;
        step();
        grst = 1'b0;
    endtask

    // Waits (bounded) for a CPX request, checks it, then grants it in WAIT.
    task automatic drain_one(input logic [7:0] exp_dest, input logic [144:0] exp_dat, input string nm);
        int k = 0;
        while (fpu_cpx_req_cq == 8'h00 && k < 10) begin
            step();
            k++;
        end
        n_checks++;
        if (fpu_cpx_req_cq !== exp_dest) begin
            n_fail++;
            $display("FAIL %s_req: got %h want %h", nm, fpu_cpx_req_cq, exp_dest);
        end
        step();
        n_checks++;
        if (fpu_cpx_data_ca !== exp_dat) begin
            n_fail++;
            $display("FAIL %s_data: got %h want %h", nm, fpu_cpx_data_ca, exp_dat);
        end
        cpx_fp_grant_cx = exp_dest;
        step();
        cpx_fp_grant_cx = '0;
    endtask

    task automatic test_reset();
        grst = 1'b1;
        fp_cpx_req_cq = 8'hFF;
        fp_cpx_data_ca = '1;
        cpx_fp_grant_cx = 8'hFF;
        step();
        step();
        n_checks++;
        if (fpu_cpx_req_cq !== 8'h00) begin n_fail++; $display("FAIL rst_req: got %h want 00", fpu_cpx_req_cq); end
        n_checks++;
        if (fpu_cpx_data_ca !== 145'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", fpu_cpx_data_ca); end
        n_checks++;
        if (obuf_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", obuf_cnt); end
        n_checks++;
        if (obuf_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", obuf_stall); end
        n_checks++;
        if ({ovfl_err, tmo_err} !== 2'b00) begin n_fail++; $display("FAIL rst_err: got %b want 00", {ovfl_err, tmo_err}); end
        grst = 1'b0;
        fp_cpx_req_cq = '0;
        fp_cpx_data_ca = '0;
        cpx_fp_grant_cx = '0;
        step();
        step();
        n_checks++;
        if ({fpu_cpx_req_cq, obuf_cnt} !== 11'h0) begin n_fail++; $display("FAIL rst_after: got req %h cnt %0d want 00/0", fpu_cpx_req_cq, obuf_cnt); end
    endtask

    task automatic test_single();
        do_reset();
        fp_cpx_req_cq = 8'h04;                 // N
        step();
        fp_cpx_req_cq = '0; fp_cpx_data_ca = D_ABCD; // N+1
        step();
        fp_cpx_data_ca = '0;                   // N+2
        n_checks++;
        if (obuf_cnt !== 3'd1) begin n_fail++; $display("FAIL single_cnt_n2: got %0d want 1", obuf_cnt); end
        n_checks++;
        if (fpu_cpx_req_cq !== 8'h00) begin n_fail++; $display("FAIL single_req_n2: got %h want 00", fpu_cpx_req_cq); end
        step();                                // N+3
        n_checks++;
        if (fpu_cpx_req_cq !== 8'h04) begin n_fail++; $display("FAIL single_req_n3: got %h want 04", fpu_cpx_req_cq); end
        n_checks++;
        if (fpu_cpx_data_ca !== 145'h0) begin n_fail++; $display("FAIL single_data_n3: got %h want 0", fpu_cpx_data_ca); end
        step();                                // N+4
        n_checks++;
        if (fpu_cpx_data_ca !== D_ABCD) begin n_fail++; $display("FAIL single_data_n4: got %h want %h", fpu_cpx_data_ca, D_ABCD); end
        n_checks++;
        if (fpu_cpx_req_cq !== 8'h00) begin n_fail++; $display("FAIL single_req_n4: got %h want 00", fpu_cpx_req_cq); end
        step();                                // N+5
        step();                                // N+6
        n_checks++;
        if (fpu_cpx_data_ca !== D_ABCD) begin n_fail++; $display("FAIL single_data_n6: got %h want %h", fpu_cpx_data_ca, D_ABCD); end
        cpx_fp_grant_cx = 8'h04;
        step();                                // N+7
        cpx_fp_grant_cx = '0;
        n_checks++;
        if (obuf_cnt !== 3'd0) begin n_fail++; $display("FAIL single_cnt_n7: got %0d want 0", obuf_cnt); end
        n_checks++;
        if (fpu_cpx_data_ca !== 145'h0) begin n_fail++; $display("FAIL single_data_n7: got %h want 0", fpu_cpx_data_ca); end
        step();                                // N+8: IDLE, no new request
        n_checks++;
        if (fpu_cpx_req_cq !== 8'h00) begin n_fail++; $display("FAIL single_idle_n8: got %h want 00", fpu_cpx_req_cq); end
    endtask

    task automatic test_fill();
        do_reset();
        fp_cpx_req_cq = 8'h01;                                   // A
        step();
        fp_cpx_req_cq = 8'h02; fp_cpx_data_ca = D1;              // A+1
        n_checks++;
        if (obuf_stall !== 1'b0) begin n_fail++; $display("FAIL fill_stall_a1: got %b want 0", obuf_stall); end
        step();
        fp_cpx_req_cq = 8'h04; fp_cpx_data_ca = D2;              // A+2
        n_checks++;
        if (obuf_stall !== 1'b0) begin n_fail++; $display("FAIL fill_stall_a2: got %b want 0", obuf_stall); end
        step();
        fp_cpx_req_cq = 8'h00; fp_cpx_data_ca = D3;              // A+3
        n_checks++;
        if (obuf_stall !== 1'b1) begin n_fail++; $display("FAIL fill_stall_a3: got %b want 1", obuf_stall); end
        step();
        fp_cpx_req_cq = 8'h08; fp_cpx_data_ca = '0;              // A+4 forced 4th
        step();
        fp_cpx_req_cq = 8'h10; fp_cpx_data_ca = D4;              // A+5 forced 5th
        step();
        fp_cpx_req_cq = 8'h00; fp_cpx_data_ca = D5;              // A+6
        n_checks++;
        if (obuf_cnt !== 3'd4 || ovfl_err !== 1'b0) begin n_fail++; $display("FAIL fill_full_a6: got cnt %0d ovfl %b want 4/0", obuf_cnt, ovfl_err); end
        step();
        fp_cpx_data_ca = '0;                                     // A+7
        n_checks++;
        if (ovfl_err !== 1'b1) begin n_fail++; $display("FAIL fill_ovfl: got %b want 1", ovfl_err); end
        n_checks++;
        if (obuf_cnt !== 3'd4) begin n_fail++; $display("FAIL fill_cnt_a7: got %0d want 4", obuf_cnt); end
        n_checks++;
        if (fpu_cpx_data_ca !== D1) begin n_fail++; $display("FAIL fill_head: got %h want %h", fpu_cpx_data_ca, D1); end
        // The head is already in WAIT; grant it, then drain the rest in order.
        cpx_fp_grant_cx = 8'h01;
        step();
        cpx_fp_grant_cx = '0;
        drain_one(8'h02, D2, "fill_d2");
        drain_one(8'h04, D3, "fill_d3");
        drain_one(8'h08, D4, "fill_d4");
        repeat (4) step();
        n_checks++;
        if (obuf_cnt !== 3'd0 || fpu_cpx_req_cq !== 8'h00 || ovfl_err !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_dropped: got cnt %0d req %h ovfl %b want 0/00/1", obuf_cnt, fpu_cpx_req_cq, ovfl_err);
        end
    endtask

    task automatic test_pushpop_full();
        do_reset();
        fp_cpx_req_cq = 8'h01;                                   // 0
        step();
        fp_cpx_req_cq = 8'h02; fp_cpx_data_ca = D1;              // 1
        step();
        fp_cpx_req_cq = 8'h04; fp_cpx_data_ca = D2;              // 2
        step();
        fp_cpx_req_cq = 8'h08; fp_cpx_data_ca = D3;              // 3
        step();
        fp_cpx_req_cq = 8'h20; fp_cpx_data_ca = D4;              // 4
        step();
        fp_cpx_req_cq = 8'h00; fp_cpx_data_ca = D6;              // 5: push D6 while popping D1
        n_checks++;
        if (obuf_cnt !== 3'd4 || fpu_cpx_data_ca !== D1) begin
            n_fail++;
            $display("FAIL pp_pre: got cnt %0d data %h want 4/%h", obuf_cnt, fpu_cpx_data_ca, D1);
        end
        cpx_fp_grant_cx = 8'h01;
        step();
        cpx_fp_grant_cx = '0; fp_cpx_data_ca = '0;               // 6
        n_checks++;
        if (obuf_cnt !== 3'd4) begin n_fail++; $display("FAIL pp_cnt: got %0d want 4", obuf_cnt); end
        n_checks++;
        if (ovfl_err !== 1'b0) begin n_fail++; $display("FAIL pp_ovfl: got %b want 0", ovfl_err); end
        n_checks++;
        if (fpu_cpx_req_cq !== 8'h02) begin n_fail++; $display("FAIL pp_b2b_req: got %h want 02", fpu_cpx_req_cq); end
        drain_one(8'h02, D2, "pp_d2");
        drain_one(8'h04, D3, "pp_d3");
        drain_one(8'h08, D4, "pp_d4");
        drain_one(8'h20, D6, "pp_d6");
        n_checks++;
        if (obuf_cnt !== 3'd0) begin n_fail++; $display("FAIL pp_empty: got %0d want 0", obuf_cnt); end
    endtask

    task automatic test_wrong_grant();
        int k = 0;
        do_reset();
        fp_cpx_req_cq = 8'h01;
        step();
        fp_cpx_req_cq = '0; fp_cpx_data_ca = D3;
        step();
        fp_cpx_data_ca = '0;
        while (fpu_cpx_req_cq == 8'h00 && k < 10) begin
            step();
            k++;
        end
        n_checks++;
        if (fpu_cpx_req_cq !== 8'h01) begin n_fail++; $display("FAIL wg_req: got %h want 01", fpu_cpx_req_cq); end
        cpx_fp_grant_cx = 8'h01;                 // grant during REQ must be ignored
        step();
        n_checks++;
        if (obuf_cnt !== 3'd1 || fpu_cpx_data_ca !== D3) begin
            n_fail++;
            $display("FAIL wg_req_grant: got cnt %0d data %h want 1/%h", obuf_cnt, fpu_cpx_data_ca, D3);
        end
        cpx_fp_grant_cx = 8'h02;                 // wrong destination
        step();
        cpx_fp_grant_cx = '0;
        n_checks++;
        if (obuf_cnt !== 3'd1 || fpu_cpx_data_ca !== D3 || fpu_cpx_req_cq !== 8'h00) begin
            n_fail++;
            $display("FAIL wg_hold: got cnt %0d data %h req %h want 1/%h/00", obuf_cnt, fpu_cpx_data_ca, fpu_cpx_req_cq, D3);
        end
        cpx_fp_grant_cx = 8'h01;
        step();
        cpx_fp_grant_cx = '0;
        n_checks++;
        if (obuf_cnt !== 3'd0 || fpu_cpx_data_ca !== 145'h0) begin
            n_fail++;
            $display("FAIL wg_pop: got cnt %0d data %h want 0/0", obuf_cnt, fpu_cpx_data_ca);
        end
    endtask

    task automatic test_timeout();
        int k = 0;
        int extra_req = 0;
        do_reset();
        fp_cpx_req_cq = 8'h08;
        step();
        fp_cpx_req_cq = '0; fp_cpx_data_ca = D5;
        step();
        fp_cpx_data_ca = '0;
        while (fpu_cpx_req_cq == 8'h00 && k < 10) begin
            step();
            k++;
        end
        n_checks++;
        if (fpu_cpx_req_cq !== 8'h08) begin n_fail++; $display("FAIL tmo_req: got %h want 08", fpu_cpx_req_cq); end
        step();                                   // first WAIT cycle
        repeat (254) begin
            if (fpu_cpx_req_cq !== 8'h00) extra_req++;
            step();
        end
        n_checks++;                               // in the 255th WAIT cycle
        if (tmo_err !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b want 0", tmo_err); end
        step();
        n_checks++;
        if (tmo_err !== 1'b1) begin n_fail++; $display("FAIL tmo_set: got %b want 1", tmo_err); end
        repeat (3) begin
            if (fpu_cpx_req_cq !== 8'h00) extra_req++;
            step();
        end
        n_checks++;
        if (extra_req !== 0) begin n_fail++; $display("FAIL tmo_no_retry: got %0d request cycles want 0", extra_req); end
        n_checks++;
        if (fpu_cpx_data_ca !== D5) begin n_fail++; $display("FAIL tmo_data: got %h want %h", fpu_cpx_data_ca, D5); end
        cpx_fp_grant_cx = 8'h08;
        step();
        cpx_fp_grant_cx = '0;
        n_checks++;
        if (obuf_cnt !== 3'd0 || tmo_err !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_late_pop: got cnt %0d tmo %b want 0/1", obuf_cnt, tmo_err);
        end
    endtask

    task automatic test_reset_in_wait();
        int k = 0;
        int bad = 0;
        do_reset();
        fp_cpx_req_cq = 8'h01;
        step();
        fp_cpx_req_cq = 8'h02; fp_cpx_data_ca = D1;
        step();
        fp_cpx_req_cq = 8'h00; fp_cpx_data_ca = D2;
        step();
        fp_cpx_data_ca = '0;
        while (fpu_cpx_req_cq == 8'h00 && k < 10) begin
            step();
            k++;
        end
        step();                                   // WAIT with two entries
        n_checks++;
        if (obuf_cnt !== 3'd2 || fpu_cpx_data_ca !== D1) begin
            n_fail++;
            $display("FAIL rw_pre: got cnt %0d data %h want 2/%h", obuf_cnt, fpu_cpx_data_ca, D1);
        end
        fp_cpx_req_cq = 8'h40;                    // leaves a request pending in req_ca
        step();
        fp_cpx_req_cq = 8'h00; fp_cpx_data_ca = D6;
        grst = 1'b1;
        cpx_fp_grant_cx = 8'h01;                  // grant during reset is ignored
        step();
        grst = 1'b0;
        cpx_fp_grant_cx = '0;
        fp_cpx_data_ca = '0;
        n_checks++;
        if (fpu_cpx_req_cq !== 8'h00 || fpu_cpx_data_ca !== 145'h0) begin
            n_fail++;
            $display("FAIL rw_out: got req %h data %h want 00/0", fpu_cpx_req_cq, fpu_cpx_data_ca);
        end
        n_checks++;
        if (obuf_cnt !== 3'd0 || obuf_stall !== 1'b0 || ovfl_err !== 1'b0 || tmo_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_state: got cnt %0d stall %b ovfl %b tmo %b want 0/0/0/0", obuf_cnt, obuf_stall, ovfl_err, tmo_err);
        end
        repeat (5) begin
            step();
            if (fpu_cpx_req_cq !== 8'h00 || obuf_cnt !== 3'd0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL rw_quiet: got %0d busy cycles want 0", bad); end
    endtask

    initial begin
        grst = 1'b1;
        fp_cpx_req_cq = '0;
        fp_cpx_data_ca = '0;
        cpx_fp_grant_cx = '0;
        test_reset();
        test_single();
        test_fill();
        test_pushpop_full();
        test_wrong_grant();
        test_timeout();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
